// File: rtl/pitch_meas_if.sv
// pitch_meas_if -- tone input and measurement results of pitch_meas.
//
// Signals:
//   tone_in       tone to be measured (driven by the tone source)
//   period        last locked period in clk cycles, 0 when not locked
//   period_valid  one-cycle pulse each time period is refreshed while locked
//   locked        tone is stable within tolerance
//   silent        no tone present
//   state_dbg     current FSM state (0 IDLE, 1 ARMED, 2 TRACK)
//   cnt_dbg       current value of the period counter
//
// Handshake: period_valid is a qualifier-only strobe with no ready. The
// consumer must take period in the cycle period_valid is high; there is no
// backpressure, and period also stays readable while locked is high.
//
// Modports: master = pitch_meas, slave = the consumer that also drives tone_in.
interface pitch_meas_if #(
  parameter int CNT_W = 20
);
  logic             tone_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             silent;
  logic [1:0]       state_dbg;
  logic [CNT_W-1:0] cnt_dbg;

  modport master (
    input  tone_in,
    output period, period_valid, locked, silent, state_dbg, cnt_dbg
  );

  modport slave (
    output tone_in,
    input  period, period_valid, locked, silent, state_dbg, cnt_dbg
  );
endinterface

// File: rtl/pitch_meas.sv
// pitch_meas -- measures the period of an incoming square-wave tone in clk
// cycles, reports it once consecutive periods agree, and flags silence.
//
// Ports:
//   clk     system clock, rising edge
//   reset_  asynchronous active-low reset
//   pm      pitch_meas_if.master: tone_in in; period, period_valid, locked,
//           silent, state_dbg, cnt_dbg out
module pitch_meas #(
  parameter int CNT_W      = 20,
  parameter int MIN_PERIOD = 16,
  parameter int TIMEOUT    = 1000000,
  parameter int TOL        = 4,
  parameter int LOCK_N     = 3
) (
  input  logic         clk,
  input  logic         reset_,
  pitch_meas_if.master pm
);

  localparam int MW = $clog2(LOCK_N + 1);

  localparam logic [CNT_W-1:0] MIN_V     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TIMEOUT_V = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   TOL_V     = (CNT_W + 1)'(TOL);
  localparam logic [MW-1:0]    LOCK_V    = MW'(LOCK_N);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    TRACK = 2'd2
  } state_t;

  state_t           state;
  logic             sync1, sync2, prev_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] prev_sample;
  logic [MW-1:0]    match_cnt;
  logic [CNT_W-1:0] period_r;
  logic             period_valid_r, locked_r, silent_r;

  // Input synchronizer plus a delayed copy for edge detection.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      prev_s <= 1'b0;
    end else begin
      sync1  <= pm.tone_in;
      sync2  <= sync1;
      prev_s <= sync2;
    end
  end

  logic             rise, accept, timeout_hit, is_match, lock_next;
  logic [CNT_W:0]   diff_raw, diff_abs;
  logic [MW-1:0]    match_inc;

  always_comb begin
    rise        = sync2 & ~prev_s;
    // Short spacings are glitches, except the very first edge out of IDLE,
    // which only starts the measurement.
    accept      = rise && ((state == IDLE) || (cnt >= MIN_V));
    timeout_hit = (cnt >= TIMEOUT_V);
    // Unsigned distance in one extra bit so the sign of the subtraction is
    // available and the magnitude never overflows.
    diff_raw    = {1'b0, cnt} - {1'b0, prev_sample};
    diff_abs    = diff_raw[CNT_W] ? (~diff_raw + 1'b1) : diff_raw;
    is_match    = (diff_abs <= TOL_V);
    match_inc   = (match_cnt >= LOCK_V) ? LOCK_V : (match_cnt + 1'b1);
    lock_next   = locked_r || (match_inc == LOCK_V);
  end

  // Period counter: restarts at 1 on an accepted edge so that the value seen
  // on the next accepted edge equals the edge spacing. Saturates, never wraps.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= CNT_W'(1);
    end else if (cnt != {CNT_W{1'b1}}) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Measurement FSM with registered outputs. An accepted edge takes priority
  // over the timeout when both happen in the same cycle.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state          <= IDLE;
      prev_sample    <= '0;
      match_cnt      <= '0;
      period_r       <= '0;
      period_valid_r <= 1'b0;
      locked_r       <= 1'b0;
      silent_r       <= 1'b1;
    end else begin
      period_valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            state    <= ARMED;
            silent_r <= 1'b0;
          end
        end
        ARMED: begin
          if (accept) begin
            prev_sample <= cnt;
            match_cnt   <= '0;
            state       <= TRACK;
          end else if (timeout_hit) begin
            state     <= IDLE;
            silent_r  <= 1'b1;
            match_cnt <= '0;
            locked_r  <= 1'b0;
            period_r  <= '0;
          end
        end
        TRACK: begin
          if (accept) begin
            prev_sample <= cnt;
            if (is_match) begin
              match_cnt <= match_inc;
              locked_r  <= lock_next;
              if (lock_next) begin
                period_r       <= cnt;
                period_valid_r <= 1'b1;
              end
            end else begin
              match_cnt <= '0;
              locked_r  <= 1'b0;
              period_r  <= '0;
            end
          end else if (timeout_hit) begin
            state     <= IDLE;
            silent_r  <= 1'b1;
            match_cnt <= '0;
            locked_r  <= 1'b0;
            period_r  <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign pm.period       = period_r;
  assign pm.period_valid = period_valid_r;
  assign pm.locked       = locked_r;
  assign pm.silent       = silent_r;
  assign pm.state_dbg    = state;
  assign pm.cnt_dbg      = cnt;

endmodule

// File: doc/pitch_meas.md
Name: pitch_meas

Overview:
- Receive-side counterpart of the tone divider: measures the period of an incoming square-wave tone in system-clock cycles.
- Recovers the 20-bit divider-domain period value and reports it once the tone is stable.
- Flags silence when no edges arrive.
- Sits between the external tone/feedback input and the note-recognition / scale-matching logic.

Parameters:
- CNT_W, 20, width of the period counter and the period output.
- MIN_PERIOD, 16, accepted samples must be >= this; shorter edge spacings are treated as glitches.
- TIMEOUT, 1000000, cycles without an accepted edge before declaring silence (must be < 2^CNT_W).
- TOL, 4, maximum absolute difference between consecutive samples that still counts as a match.
- LOCK_N, 3, consecutive matching samples required to assert locked.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset_  input  1  asynchronous, active-low reset.
- tone_in  input  1  asynchronous square-wave tone to be measured.
- period  output  CNT_W  last locked period in clk cycles; 0 when not locked.
- period_valid  output  1  one-cycle pulse each time period is updated while locked.
- locked  output  1  high while the tone is stable within TOL.
- silent  output  1  high while no tone is present.

Behaviour:
- Reset (async, reset_ low):
  - period=0, period_valid=0, locked=0, silent=1.
  - Synchronizer flops=0, counter=0, match count=0, previous sample=0.
  - State=IDLE.
- Input path:
  - tone_in passes through a 2-flop synchronizer, then a registered previous-value flop.
  - rise = sync2 & ~prev. The rise is seen 3 clk edges after the tone_in transition.
- Counter (cnt, CNT_W bits):
  - On an accepted rise: cnt <= 1.
  - Otherwise: cnt <= cnt+1, saturating at all-ones (never wraps).
- Sample and acceptance:
  - On a rise, sample = cnt.
  - A rise is accepted only if state==IDLE, or cnt >= MIN_PERIOD.
  - A rejected rise changes nothing: the counter keeps running and no state change occurs.
- States:
  - IDLE: silent=1. On an accepted rise -> ARMED. No sample is used.
  - ARMED: on an accepted rise, store the sample as prev_sample, match count=0 -> TRACK. Still no output update.
  - TRACK: on each accepted rise, compare |sample - prev_sample| (unsigned, computed in CNT_W+1 bits).
    - If <= TOL: match count++ (saturate at LOCK_N). When the match count reaches LOCK_N, locked <= 1.
    - If > TOL: match count=0, locked <= 0.
    - Always prev_sample <= sample.
- Output update:
  - When locked is 1 after the update above, period <= sample and period_valid pulses in the same registered cycle (one cycle after the rise cycle).
  - The first valid pulse accompanies the 0->1 transition of locked.
- Unlock: when locked falls, period <= 0 in that cycle and no pulse.
- silent:
  - Deasserts on the cycle the state leaves IDLE.
  - Reasserts when in ARMED or TRACK and cnt reaches TIMEOUT. Same cycle: state -> IDLE, locked=0, period=0, match count=0, no pulse.
- Simultaneous events: if a rise and the timeout occur in the same cycle, the rise wins (sample processed, no timeout).
- Reset mid-operation: everything returns to reset values immediately, with no pulse on exit.
- period_valid is never high for two consecutive cycles (edges are >= MIN_PERIOD apart).

Test Plan:
- Reset then 1000-cycle-period tone (500 high / 500 low) -> silent falls after the first rise; period_valid first pulses on the 5th rise (IDLE, ARMED, 3 matches) with period=1000 and locked=1; a pulse follows every 1000 cycles.
- Locked at 1000, then periods 1003, 1006 -> stays locked, period=1003 then 1006; next period 1020 -> locked=0, period=0, no pulse; re-locks after 3 further matching periods.
- 3-cycle glitch pulses injected inside a locked 1000-cycle tone -> rejected (cnt<16), locked stays 1, periods still reported as 1000.
- Tone stops while locked -> exactly TIMEOUT=1000000 cycles after the last rise: silent=1, locked=0, period=0; a new tone requires the full IDLE->ARMED->lock sequence again.
- Constant-high tone_in for 2^20+5 cycles with TIMEOUT set to all-ones -> counter saturates at 1048575 without wrapping, silent asserts, no spurious pulse.
- reset_ asserted asynchronously mid-lock (between clk edges) -> all outputs at reset values immediately; after release the lock sequence restarts from IDLE.
